// File: rtl/alu_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// alu_cmd_sequencer
//
// Purpose:
//   Command front end and write-back stage for an external 16-bit
//   combinational ALU (opc/ina/inb/inc -> w/zer/neg). Commands name
//   register-file entries. Operands are read from an NREG x WIDTH register
//   file and latched. The ALU is then driven purely from those latches. The
//   ALU result is captured into res_data, the sticky Z/N flags and the
//   destination register. One command completes every 3 cycles.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   cmd_valid/ready   command handshake; fields sampled on the accept edge
//   cmd_opc/dst/sa/sb/cin  opcode, destination, source A/B, carry-in
//   ld_en/addr/data   register-file load port (honoured only while idle)
//   rd_addr/rd_data   combinational debug read of the register file
//   alu_opc/ina/inb/inc   registered operands towards the ALU
//   alu_w/zer/neg     ALU result and status
//   res_data          last captured (non-NOP) result
//   flag_z/flag_n     sticky zero / negative flags
//   done              one-cycle pulse per completed command
// ---------------------------------------------------------------------------
module alu_cmd_sequencer #(
    parameter int WIDTH = 16,
    parameter int NREG  = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_opc,
    input  logic [AW-1:0]    cmd_dst,
    input  logic [AW-1:0]    cmd_sa,
    input  logic [AW-1:0]    cmd_sb,
    input  logic             cmd_cin,
    input  logic             ld_en,
    input  logic [AW-1:0]    ld_addr,
    input  logic [WIDTH-1:0] ld_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic [2:0]       alu_opc,
    output logic [WIDTH-1:0] alu_ina,
    output logic [WIDTH-1:0] alu_inb,
    output logic             alu_inc,
    input  logic [WIDTH-1:0] alu_w,
    input  logic             alu_zer,
    input  logic             alu_neg,
    output logic [WIDTH-1:0] res_data,
    output logic             flag_z,
    output logic             flag_n,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] OPC_NOP = 3'b111;

    state_t           state_q;
    logic [2:0]       opc_q;
    logic [AW-1:0]    dst_q;
    logic             cin_q;
    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opb_q;
    logic [WIDTH-1:0] res_q;
    logic             fz_q;
    logic             fn_q;
    logic             done_q;
    logic [WIDTH-1:0] rf_q [NREG];

    // Opcode 111 has no ALU meaning: the command still completes with a done
    // pulse, but nothing architectural is updated.
    logic wb_en_d;
    assign wb_en_d = (opc_q != OPC_NOP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            opc_q   <= '0;
            dst_q   <= '0;
            cin_q   <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            fz_q    <= 1'b0;
            fn_q    <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    // A load on the accept edge is written, but the command
                    // latches the old contents. Both sides sample rf_q.
                    if (ld_en) begin
                        rf_q[ld_addr] <= ld_data;
                    end
                    if (cmd_valid) begin
                        opc_q   <= cmd_opc;
                        dst_q   <= cmd_dst;
                        cin_q   <= cmd_cin;
                        opa_q   <= rf_q[cmd_sa];
                        opb_q   <= rf_q[cmd_sb];
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    // Operands are already latched, so dst may alias sa/sb.
                    if (wb_en_d) begin
                        res_q        <= alu_w;
                        fz_q         <= alu_zer;
                        fn_q         <= alu_neg;
                        rf_q[dst_q]  <= alu_w;
                    end
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Ready is gated by rst so nothing is accepted while reset is held.
    assign cmd_ready = (state_q == IDLE) && !rst;

    assign rd_data  = rf_q[rd_addr];
    assign alu_opc  = opc_q;
    assign alu_ina  = opa_q;
    assign alu_inb  = opb_q;
    assign alu_inc  = cin_q;
    assign res_data = res_q;
    assign flag_z   = fz_q;
    assign flag_n   = fn_q;
    assign done     = done_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
module tb_alu_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_cin, ld_en;
    logic [2:0]  cmd_opc, cmd_dst, cmd_sa, cmd_sb, ld_addr, rd_addr;
    logic [15:0] ld_data, rd_data;
    logic [2:0]  alu_opc;
    logic [15:0] alu_ina, alu_inb, alu_w, res_data;
    logic        alu_inc, alu_zer, alu_neg, flag_z, flag_n, done;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference architectural state
    logic [15:0] ref_rf [8];
    logic [15:0] ref_res;
    logic        ref_z, ref_n;

    always #5 clk = ~clk;

    alu_cmd_sequencer dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opc(cmd_opc), .cmd_dst(cmd_dst), .cmd_sa(cmd_sa), .cmd_sb(cmd_sb),
        .cmd_cin(cmd_cin),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .alu_opc(alu_opc), .alu_ina(alu_ina), .alu_inb(alu_inb), .alu_inc(alu_inc),
        .alu_w(alu_w), .alu_zer(alu_zer), .alu_neg(alu_neg),
        .res_data(res_data), .flag_z(flag_z), .flag_n(flag_n), .done(done)
    );

    // Behavioural stand-in for the external ALU. 111 yields a distinctive
    // value so any write-back of a NOP would be visible.
    function automatic logic [15:0] alu_fn(input logic [2:0] op, input logic [15:0] a,
                                           input logic [15:0] b, input logic c);
        case (op)
            3'd0:    return -a;
            3'd1:    return a - b;
            3'd2:    return a + b + {15'd0, c};
            3'd3:    return a + {b[15], b[15:1]};
            3'd4:    return a & b;
            3'd5:    return a | b;
            3'd6:    return {a[7:0], b[7:0]};
            default: return 16'hDEAD;
        endcase
    endfunction

    always_comb begin
        alu_w   = alu_fn(alu_opc, alu_ina, alu_inb, alu_inc);
        alu_zer = (alu_w == 16'd0);
        alu_neg = alu_w[15];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        else n_pass++;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 10 && cmd_ready !== 1'b1; i++) begin
            @(posedge clk); #1;
        end
        chk("ready", cmd_ready, 1);
    endtask

    task automatic check_state(input string tag);
        for (int a = 0; a < 8; a++) begin
            rd_addr = a[2:0];
            #1;
            chk(tag, rd_data, ref_rf[a]);
        end
        chk({tag, "_res"}, res_data, ref_res);
        chk({tag, "_z"}, flag_z, ref_z);
        chk({tag, "_n"}, flag_n, ref_n);
    endtask

    task automatic load(input logic [2:0] a, input logic [15:0] d);
        wait_ready();
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(posedge clk); #1;
        ld_en = 1'b0;
        ref_rf[a] = d;
    endtask

    // One command with full timing checks. ld_same loads on the accept edge,
    // ld_exec attempts a load during EXEC (must be ignored).
    task automatic run_cmd(input logic [2:0] op, input logic [2:0] dst, input logic [2:0] sa,
                           input logic [2:0] sb, input logic cin, input logic ld_same,
                           input logic ld_exec, input logic [2:0] la, input logic [15:0] ldd);
        logic [15:0] a, b, w;
        wait_ready();
        a = ref_rf[sa]; b = ref_rf[sb];
        w = alu_fn(op, a, b, cin);
        cmd_valid = 1'b1; cmd_opc = op; cmd_dst = dst; cmd_sa = sa; cmd_sb = sb; cmd_cin = cin;
        ld_en = ld_same; ld_addr = la; ld_data = ldd;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_opc = $urandom; cmd_sa = $urandom; cmd_sb = $urandom;
        ld_en = ld_exec; ld_addr = la; ld_data = ~ldd;
        if (ld_same) ref_rf[la] = ldd;
        chk("exec_done", done, 0);
        chk("exec_ready", cmd_ready, 0);
        chk("alu_opc", alu_opc, op);
        chk("alu_ina", alu_ina, a);
        chk("alu_inb", alu_inb, b);
        chk("alu_inc", alu_inc, cin);
        @(posedge clk); #1;
        ld_en = 1'b0;
        if (op != 3'b111) begin
            ref_rf[dst] = w; ref_res = w; ref_z = (w == 16'd0); ref_n = w[15];
        end
        chk("done_pulse", done, 1);
        chk("done_ready", cmd_ready, 0);
        chk("wb_res", res_data, ref_res);
        chk("wb_z", flag_z, ref_z);
        chk("wb_n", flag_n, ref_n);
        @(posedge clk); #1;
        chk("done_end", done, 0);
        chk("idle_ready", cmd_ready, 1);
    endtask

    task automatic reset_ref();
        for (int a = 0; a < 8; a++) ref_rf[a] = 16'd0;
        ref_res = 16'd0; ref_z = 1'b0; ref_n = 1'b0;
    endtask

    initial begin
        int acc, dn, prev;
        rst = 1'b1; cmd_valid = 1'b0; cmd_opc = '0; cmd_dst = '0; cmd_sa = '0; cmd_sb = '0;
        cmd_cin = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0; rd_addr = '0;
        reset_ref();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", cmd_ready, 0);
        chk("rst_done", done, 0);
        chk("rst_ina", alu_ina, 0);
        rst = 1'b0;
        #1;
        check_state("rst_rf");

        // ADD: 5 + 3 + 1
        load(3'd1, 16'h0005);
        load(3'd2, 16'h0003);
        run_cmd(3'b010, 3'd3, 3'd1, 3'd2, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0);
        chk("add_lit", res_data, 16'h0009);
        check_state("add");

        // Negate, then AND with R0
        run_cmd(3'b000, 3'd4, 3'd1, 3'd1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
        chk("neg_lit", res_data, 16'hFFFB);
        chk("neg_n", flag_n, 1);
        run_cmd(3'b100, 3'd4, 3'd1, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
        chk("and_lit", res_data, 16'h0000);
        chk("and_z", flag_z, 1);
        check_state("negand");

        // Shift-add and byte merge
        load(3'd5, 16'h0002);
        load(3'd6, 16'h8000);
        run_cmd(3'b011, 3'd5, 3'd5, 3'd6, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
        chk("shadd_lit", res_data, 16'hC002);
        load(3'd1, 16'h1234);
        load(3'd2, 16'h5678);
        run_cmd(3'b110, 3'd7, 3'd1, 3'd2, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0);
        chk("merge_lit", res_data, 16'h3478);

        // NOP: nothing changes, done still pulses
        run_cmd(3'b111, 3'd3, 3'd1, 3'd2, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0);
        check_state("nop");

        // Load during EXEC ignored; load on accept edge seen only afterwards
        run_cmd(3'b010, 3'd6, 3'd1, 3'd2, 1'b0, 1'b0, 1'b1, 3'd2, 16'hBEEF);
        check_state("ld_exec");
        run_cmd(3'b010, 3'd0, 3'd1, 3'd2, 1'b0, 1'b1, 1'b0, 3'd1, 16'h7777);
        check_state("ld_same");

        // Back-to-back: valid held high, R7 += 1 per command
        load(3'd0, 16'h0000);
        load(3'd7, 16'h00F0);
        wait_ready();
        cmd_valid = 1'b1; cmd_opc = 3'b010; cmd_dst = 3'd7; cmd_sa = 3'd7; cmd_sb = 3'd0; cmd_cin = 1'b1;
        acc = 0; dn = 0; prev = -1;
        for (int i = 0; i < 18; i++) begin
            if (cmd_ready === 1'b1) begin
                if (prev >= 0) chk("acc_gap", i - prev, 3);
                prev = i; acc++;
            end
            if (done === 1'b1) dn++;
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        chk("acc_count", acc, 6);
        chk("done_count", dn, 6);
        ref_rf[7] = 16'h00F6; ref_res = 16'h00F6; ref_z = 1'b0; ref_n = 1'b0;
        check_state("b2b");

        // Randomized traffic against the reference model
        for (int k = 0; k < 40; k++) begin
            logic [2:0] op;
            if ($urandom_range(0, 3) == 0) load($urandom, $urandom);
            op = $urandom;
            run_cmd(op, $urandom, $urandom, $urandom, $urandom,
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                    $urandom, $urandom);
        end
        check_state("rand");

        // Reset in the middle of EXEC
        load(3'd3, 16'hAAAA);
        wait_ready();
        cmd_valid = 1'b1; cmd_opc = 3'b010; cmd_dst = 3'd5; cmd_sa = 3'd3; cmd_sb = 3'd3; cmd_cin = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", cmd_ready, 0);
        chk("mid_rst_opc", alu_opc, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("post_rst_ready", cmd_ready, 1);
        chk("post_rst_done", done, 0);
        @(posedge clk); #1;
        chk("post_rst_nodone", done, 0);
        reset_ref();
        check_state("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
